// File: rtl/cpu_alu_issue.sv
// Issue/retire wrapper around the combinational cpu_alu: decodes MIPS-style ops,
// registers them onto the ALU inputs and captures result/zero into a skid-free response stage.
module cpu_alu_issue #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_aluop,
  input  logic [5:0]        req_funct,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] alu_input_1,
  output logic [DATA_W-1:0] alu_input_2,
  output logic [2:0]        alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_illegal,
  output logic [CNT_W-1:0]  retired_cnt
);

  logic              s1_valid_q, s1_valid_d;
  logic              s1_illegal_q, s1_illegal_d;
  logic [DATA_W-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_illegal_q, rsp_illegal_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [2:0] dec_ctrl;
  logic       dec_illegal;
  logic       s2_free, s1_adv, req_fire, rsp_fire;

  always_comb begin
    dec_ctrl    = 3'b010;
    dec_illegal = 1'b0;
    case (req_aluop)
      2'b00: dec_ctrl = 3'b010;
      2'b01: dec_ctrl = 3'b110;
      2'b10: begin
        case (req_funct)
          6'b100000: dec_ctrl = 3'b010;
          6'b100010: dec_ctrl = 3'b110;
          6'b100100: dec_ctrl = 3'b000;
          6'b100101: dec_ctrl = 3'b001;
          6'b101010: dec_ctrl = 3'b111;
          default:   dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign s2_free   = !rsp_valid_q || rsp_ready;
  assign s1_adv    = s1_valid_q && s2_free;
  assign req_ready = !s1_valid_q || s2_free;
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid_q && rsp_ready;

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_illegal_d  = s1_illegal_q;
    in1_d         = in1_q;
    in2_d         = in2_q;
    ctrl_d        = ctrl_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_illegal_d = rsp_illegal_q;
    cnt_d         = cnt_q;

    // S1: operands parked on the ALU inputs; they hold when S1 drains
    if (req_fire) begin
      s1_valid_d   = 1'b1;
      s1_illegal_d = dec_illegal;
      in1_d        = req_a;
      in2_d        = req_b;
      ctrl_d       = dec_ctrl;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // S2: capture the ALU output; illegal ops report a zeroed result and flag
    if (s1_adv) begin
      rsp_valid_d   = 1'b1;
      rsp_illegal_d = s1_illegal_q;
      rsp_result_d  = s1_illegal_q ? '0 : alu_result;
      rsp_zero_d    = s1_illegal_q ? 1'b0 : alu_zero;
    end else if (rsp_fire) begin
      rsp_valid_d = 1'b0;
    end

    if (rsp_fire) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_illegal_q  <= 1'b0;
      in1_q         <= '0;
      in2_q         <= '0;
      ctrl_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_illegal_q  <= s1_illegal_d;
      in1_q         <= in1_d;
      in2_q         <= in2_d;
      ctrl_q        <= ctrl_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
      cnt_q         <= cnt_d;
    end
  end

  assign alu_input_1 = in1_q;
  assign alu_input_2 = in2_q;
  assign alu_control = ctrl_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_illegal = rsp_illegal_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_alu_issue.sv
// Scoreboard bench for cpu_alu_issue: a behavioural cpu_alu closes the loop, and a second
// instance with a 2-bit counter shares the request/response traffic to exercise counter wrap.
module tb_cpu_alu_issue;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, rsp_ready;
  logic [1:0]        req_aluop;
  logic [5:0]        req_funct;
  logic [DATA_W-1:0] req_a, req_b;

  logic              req_ready, rsp_valid, rsp_zero, rsp_illegal, alu_zero;
  logic [DATA_W-1:0] alu_input_1, alu_input_2, alu_result, rsp_result;
  logic [2:0]        alu_control;
  logic [15:0]       retired_cnt;

  logic              req_ready2, rsp_valid2, rsp_zero2, rsp_illegal2, alu_zero2;
  logic [DATA_W-1:0] alu_input_12, alu_input_22, alu_result2, rsp_result2;
  logic [2:0]        alu_control2;
  logic [1:0]        retired_cnt2;

  int total = 0;
  int bad   = 0;
  int pushes = 0;
  int cnt_exp = 0;
  logic [33:0] sbq[$];
  logic [5:0] fns [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h3f};

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] alu_f(input logic [2:0] c, input logic [DATA_W-1:0] a, b);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  // expected {illegal, zero, result} straight from the op encoding
  function automatic logic [33:0] exp_f(input logic [1:0] op, input logic [5:0] fn,
                                        input logic [DATA_W-1:0] a, b);
    logic [DATA_W-1:0] r;
    logic ill;
    r = '0; ill = 1'b0;
    case (op)
      2'b00: r = a + b;
      2'b01: r = a - b;
      2'b10: case (fn)
        6'h20:   r = a + b;
        6'h22:   r = a - b;
        6'h24:   r = a & b;
        6'h25:   r = a | b;
        6'h2a:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: ill = 1'b1;
      endcase
      default: ill = 1'b1;
    endcase
    if (ill) return {1'b1, 1'b0, 32'd0};
    return {1'b0, (r == 0), r};
  endfunction

  assign alu_result  = alu_f(alu_control, alu_input_1, alu_input_2);
  assign alu_zero    = (alu_result == 0);
  assign alu_result2 = alu_f(alu_control2, alu_input_12, alu_input_22);
  assign alu_zero2   = (alu_result2 == 0);

  cpu_alu_issue #(.DATA_W(DATA_W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
    .alu_input_1(alu_input_1), .alu_input_2(alu_input_2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_illegal(rsp_illegal), .retired_cnt(retired_cnt));

  cpu_alu_issue #(.DATA_W(DATA_W), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready2),
    .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
    .alu_input_1(alu_input_12), .alu_input_2(alu_input_22), .alu_control(alu_control2),
    .alu_result(alu_result2), .alu_zero(alu_zero2), .rsp_valid(rsp_valid2),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result2), .rsp_zero(rsp_zero2),
    .rsp_illegal(rsp_illegal2), .retired_cnt(retired_cnt2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // handshakes are stable between negedge and the following posedge
  always @(negedge clk) begin
    if (!reset) begin
      chk("retired_cnt", retired_cnt, 64'(cnt_exp[15:0]));
      chk("retired_cnt_w2", retired_cnt2, 64'(cnt_exp[1:0]));
      chk("twin_rsp_valid", rsp_valid2, rsp_valid);
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          logic [33:0] e;
          e = sbq.pop_front();
          chk("rsp_result", rsp_result, 64'(e[31:0]));
          chk("rsp_zero", rsp_zero, 64'(e[32]));
          chk("rsp_illegal", rsp_illegal, 64'(e[33]));
          chk("twin_rsp_result", rsp_result2, 64'(e[31:0]));
        end
        cnt_exp++;
      end
      if (req_valid && req_ready) begin
        sbq.push_back(exp_f(req_aluop, req_funct, req_a, req_b));
        pushes++;
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [5:0] fn, input logic [DATA_W-1:0] a, b);
    int g;
    logic ok;
    req_aluop = op; req_funct = fn; req_a = a; req_b = b; req_valid = 1'b1;
    g = 0;
    do begin
      @(negedge clk); ok = req_ready;
      @(posedge clk); #1;
      g++;
    end while (!ok && g < 200);
    if (!ok) chk("send_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sbq.size() != 0 || rsp_valid) && g < 100) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 100) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    logic [15:0] c0;
    int p0;
    logic done;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_aluop = '0; req_funct = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_cnt", retired_cnt, 0);
    chk("rst_alu_control", alu_control, 0);
    chk("rst_alu_input_1", alu_input_1, 0);
    chk("rst_rsp_result", rsp_result, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // latency: accept at edge n, response visible after edge n+1
    req_aluop = 2'b10; req_funct = 6'b100000; req_a = 5; req_b = 7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("lat_s1_rsp_valid", rsp_valid, 0);
    chk("lat_alu_control", alu_control, 3'b010);
    chk("lat_alu_input_1", alu_input_1, 5);
    chk("lat_alu_input_2", alu_input_2, 7);
    @(posedge clk); #1;
    chk("lat_rsp_valid", rsp_valid, 1);
    chk("lat_rsp_result", rsp_result, 12);
    chk("lat_rsp_zero", rsp_zero, 0);
    chk("lat_rsp_illegal", rsp_illegal, 0);
    drain();

    send(2'b01, 6'h00, 3, 3);
    send(2'b10, 6'b101010, 2, 5);
    send(2'b10, 6'b101010, 5, 2);
    send(2'b10, 6'b101010, 32'hffff_ffff, 1);
    send(2'b10, 6'b100100, 32'hf0f0_1234, 32'h0ff0_ff00);
    send(2'b10, 6'b100101, 32'h1200_0000, 32'h0000_0034);
    send(2'b10, 6'b100010, 10, 3);
    send(2'b11, 6'b100000, 9, 9);
    drain();
    c0 = retired_cnt;
    send(2'b10, 6'b000000, 4, 4);
    drain();
    chk("illegal_counts", retired_cnt, 64'(c0 + 16'd1));
    chk("illegal_flag_held", rsp_illegal, 1);

    // backpressure: two ops fill the pipe, the rest wait for rsp_ready
    rsp_ready = 1'b0;
    p0 = pushes;
    fork
      begin
        send(2'b00, 6'h00, 10, 7);
        send(2'b01, 6'h00, 20, 5);
        send(2'b10, 6'b100101, 1, 2);
        send(2'b10, 6'b101010, 7, 7);
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        chk("bp_accepted", pushes - p0, 2);
        chk("bp_req_ready", req_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_rsp_result", rsp_result, 17);
        @(posedge clk); #2;
        chk("bp_rsp_stable", rsp_result, 17);
        chk("bp_still_blocked", pushes - p0, 2);
        rsp_ready = 1'b1;
      end
    join
    drain();
    chk("bp_all_accepted", pushes - p0, 4);

    // reset with both stages occupied
    rsp_ready = 1'b0;
    send(2'b00, 6'h00, 1, 2);
    send(2'b00, 6'h00, 3, 4);
    reset = 1'b1;
    sbq.delete();
    cnt_exp = 0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_cnt", retired_cnt, 0);
    chk("mid_rst_rsp_result", rsp_result, 0);
    chk("mid_rst_alu_control", alu_control, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_req_ready", req_ready, 1);

    // five retires on the 2-bit counter wrap to 1
    for (int i = 0; i < 5; i++) send(2'b00, 6'h00, i, 1);
    drain();
    chk("wrap_cnt2", retired_cnt2, 1);
    chk("wrap_cnt16", retired_cnt, 5);

    // random traffic with random response backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          logic [DATA_W-1:0] a, b;
          a = $urandom; b = $urandom;
          if ($urandom_range(0, 3) == 0) b = a;
          if ($urandom_range(0, 3) == 0) begin a = $urandom_range(0, 9); b = $urandom_range(0, 9); end
          send(2'($urandom_range(0, 3)), fns[$urandom_range(0, 6)], a, b);
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 2) != 0);
        end
        rsp_ready = 1'b1;
      end
    join
    drain();
    chk("final_queue_empty", sbq.size(), 0);
    chk("final_cnt", retired_cnt, 64'(cnt_exp[15:0]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end
endmodule
